// File: rtl/io_uart_tx_dev_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// io_uart_tx_dev_pkg : register map, bit positions and FSM encoding for io_uart_tx_dev
// Rev 1.0
// ----------------------------------------------------------------------------
package io_uart_tx_dev_pkg;

  localparam logic [7:0] TXDATA_OFS = 8'h00;
  localparam logic [7:0] STATUS_OFS = 8'h04;
  localparam logic [7:0] CTRL_OFS   = 8'h08;

  localparam int STATUS_BUSY_BIT  = 0;
  localparam int STATUS_FULL_BIT  = 1;
  localparam int STATUS_EMPTY_BIT = 2;
  localparam int STATUS_OVF_BIT   = 3;
  localparam int STATUS_COUNT_LSB = 8;
  localparam int STATUS_COUNT_W   = 7;

  localparam int CTRL_TX_EN_BIT  = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

endpackage
`default_nettype wire

// File: rtl/io_uart_tx_dev_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// io_sync_fifo : single-clock FIFO, power-of-two depth, head word always visible
// Rev 1.0
// ----------------------------------------------------------------------------
module io_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int             c_aw    = $clog2(DEPTH);
  localparam logic [c_aw:0]  c_depth = (c_aw + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_aw:0]    r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign full      = (r_count == c_depth);
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign rdata     = r_mem[r_rd_ptr];
  // A push against a full FIFO is dropped even when a pop frees a slot this cycle.
  assign w_push_ok = push && !full;
  assign w_pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/io_uart_tx_dev.sv
`default_nettype none
// ----------------------------------------------------------------------------
// io_uart_tx_dev : memory-mapped 8N1 UART transmitter; macro UART_TX_IRQ_EN adds irq
// Rev 1.0
// ----------------------------------------------------------------------------
module io_uart_tx_dev
  import io_uart_tx_dev_pkg::*;
#(
  parameter int CLK_DIV    = 434,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] io_address,
  input  logic        io_cs,
  input  logic        io_we,
  input  logic [31:0] io_wdata,
  output logic [31:0] io_rdata,
  output logic        tx,
  output logic        irq
);

  localparam int                  c_baud_w      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_baud_w-1:0] c_baud_reload = c_baud_w'(CLK_DIV - 1);
  localparam int                  c_cnt_w       = $clog2(FIFO_DEPTH) + 1;

  localparam logic [1:0] ST_IDLE  = TX_IDLE;
  localparam logic [1:0] ST_START = TX_START;
  localparam logic [1:0] ST_DATA  = TX_DATA;
  localparam logic [1:0] ST_STOP  = TX_STOP;

  logic [7:0]          w_ofs;
  logic                w_wr;
  logic                w_push_req;
  logic                w_ovf_set;
  logic                w_ovf_clr;
  logic                w_ctrl_wr;
  logic                w_fifo_push;
  logic                w_start_frame;
  logic                w_baud_done;
  logic                w_busy;
  logic [7:0]          w_head;
  logic                w_full;
  logic                w_empty;
  logic [c_cnt_w-1:0]  w_count;
  logic [31:0]         w_status;
  logic [31:0]         w_ctrl;
  logic                w_irq_en;
  logic                w_unused;

  logic [1:0]          r_state;
  logic [c_baud_w-1:0] r_baud;
  logic [2:0]          r_bit_idx;
  logic [7:0]          r_shift;
  logic                r_tx;
  logic                r_tx_en;
  logic                r_overflow;

  assign w_ofs       = io_address[7:0];
  assign w_wr        = io_cs && io_we;
  assign w_push_req  = w_wr && (w_ofs == TXDATA_OFS);
  assign w_ovf_set   = w_push_req && w_full;
  assign w_ovf_clr   = w_wr && (w_ofs == STATUS_OFS) && io_wdata[STATUS_OVF_BIT];
  assign w_ctrl_wr   = w_wr && (w_ofs == CTRL_OFS);
  assign w_fifo_push = w_push_req && !w_full;
  assign w_busy      = (r_state != ST_IDLE);
  assign w_baud_done = (r_baud == '0);
  assign tx          = r_tx;
  assign w_unused    = &{1'b0, io_address[11:8], io_wdata[31:8]};

  io_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_fifo_push),
    .pop   (w_start_frame),
    .wdata (io_wdata[7:0]),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  // A new frame starts from IDLE, or straight out of a finished STOP bit.
  always_comb begin
    w_start_frame = 1'b0;
    if (r_tx_en && !w_empty) begin
      if (r_state == ST_IDLE) begin
        w_start_frame = 1'b1;
      end else if ((r_state == ST_STOP) && w_baud_done) begin
        w_start_frame = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
    end else if (w_start_frame) begin
      r_state   <= ST_START;
      r_baud    <= c_baud_reload;
      r_bit_idx <= '0;
      r_shift   <= w_head;
      r_tx      <= 1'b0;
    end else begin
      case (r_state)
        ST_START: begin
          if (w_baud_done) begin
            r_state   <= ST_DATA;
            r_baud    <= c_baud_reload;
            r_bit_idx <= '0;
            r_tx      <= r_shift[0];
            r_shift   <= {1'b0, r_shift[7:1]};
          end else begin
            r_baud <= r_baud - 1'b1;
          end
        end
        ST_DATA: begin
          if (w_baud_done) begin
            r_baud <= c_baud_reload;
            if (r_bit_idx == 3'd7) begin
              r_state <= ST_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
              r_tx      <= r_shift[0];
              r_shift   <= {1'b0, r_shift[7:1]};
            end
          end else begin
            r_baud <= r_baud - 1'b1;
          end
        end
        ST_STOP: begin
          if (w_baud_done) begin
            r_state <= ST_IDLE;
          end else begin
            r_baud <= r_baud - 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_en    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (w_ctrl_wr) begin
        r_tx_en <= io_wdata[CTRL_TX_EN_BIT];
      end
      // Set beats a simultaneous W1C clear.
      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end else if (w_ovf_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

`ifdef UART_TX_IRQ_EN
  logic r_irq_en;
  logic r_irq;
  logic w_irq_en_next;

  assign w_irq_en_next = w_ctrl_wr ? io_wdata[CTRL_IRQ_EN_BIT] : r_irq_en;
  assign w_irq_en      = r_irq_en;
  assign irq           = r_irq;

  // Push and irq_en clear drop the request on the very edge that performs them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_irq_en <= w_irq_en_next;
      r_irq    <= w_irq_en_next && w_empty && !w_busy && !w_push_req;
    end
  end
`else
  assign w_irq_en = 1'b0;
  assign irq      = 1'b0;
`endif

  always_comb begin
    w_status                                            = '0;
    w_status[STATUS_BUSY_BIT]                           = w_busy;
    w_status[STATUS_FULL_BIT]                           = w_full;
    w_status[STATUS_EMPTY_BIT]                          = w_empty;
    w_status[STATUS_OVF_BIT]                            = r_overflow;
    w_status[STATUS_COUNT_LSB +: STATUS_COUNT_W]        = 7'(w_count);
  end

  always_comb begin
    w_ctrl                  = '0;
    w_ctrl[CTRL_TX_EN_BIT]  = r_tx_en;
    w_ctrl[CTRL_IRQ_EN_BIT] = w_irq_en;
  end

  always_comb begin
    io_rdata = '0;
    if (io_cs && !io_we) begin
      case (w_ofs)
        STATUS_OFS: io_rdata = w_status;
        CTRL_OFS:   io_rdata = w_ctrl;
        default:    io_rdata = '0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_io_uart_tx_dev.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_io_uart_tx_dev : scoreboard bench for io_uart_tx_dev (CLK_DIV=4, FIFO_DEPTH=4)
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_io_uart_tx_dev;

  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int FRAME      = 10 * CLK_DIV;

  logic        clk;
  logic        rst_n;
  logic [11:0] io_address;
  logic        io_cs;
  logic        io_we;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata;
  logic        tx;
  logic        irq;

  int          n_tests;
  int          n_fail;
  int          cyc;
  bit          mon_en;
  logic [7:0]  exp_q[$];
  int          starts[$];

  io_uart_tx_dev #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .io_address (io_address),
    .io_cs      (io_cs),
    .io_we      (io_we),
    .io_wdata   (io_wdata),
    .io_rdata   (io_rdata),
    .tx         (tx),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Caller sits just after a negedge; the write lands on the next rising edge.
  task automatic bus_write(input logic [11:0] a, input logic [31:0] d);
    io_cs = 1'b1; io_we = 1'b1; io_address = a; io_wdata = d;
    @(negedge clk);
    io_cs = 1'b0; io_we = 1'b0;
  endtask

  task automatic bus_read(input logic [11:0] a, output logic [31:0] d);
    io_cs = 1'b1; io_we = 1'b0; io_address = a;
    #1;
    d = io_rdata;
    io_cs = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    logic [31:0] st;
    bit          done;
    done = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      bus_read(12'h004, st);
      if (exp_q.size() == 0 && st[0] == 1'b0 && st[2] == 1'b1) begin
        done = 1'b1;
        break;
      end
    end
    check({name, "_drain"}, {31'd0, done}, 32'd1);
  endtask

  // Monitor: decode every frame on tx, sampled once per clock on the falling edge.
  initial begin : monitor
    logic [7:0] b;
    int         st;
    bit         ok;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n === 1'b1 && tx === 1'b0) begin
        st = cyc;
        ok = 1'b1;
        b  = '0;
        for (int k = 1; k < CLK_DIV; k++) begin
          @(negedge clk);
          if (tx !== 1'b0) ok = 1'b0;
        end
        for (int i = 0; i < 8; i++) begin
          @(negedge clk);
          b[i] = tx;
          for (int k = 1; k < CLK_DIV; k++) begin
            @(negedge clk);
            if (tx !== b[i]) ok = 1'b0;
          end
        end
        for (int k = 0; k < CLK_DIV; k++) begin
          @(negedge clk);
          if (tx !== 1'b1) ok = 1'b0;
        end
        starts.push_back(st);
        check("frame_timing", {31'd0, ok}, 32'd1);
        if (exp_q.size() == 0) begin
          check("unexpected_frame", {24'd0, b}, 32'hFFFF_FFFF);
        end else begin
          check("frame_byte", {24'd0, b}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin : timeout
    #1_000_000;
    $display("FAIL global_timeout: got cycle %0d, expected completion", cyc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] r;
    int          lows;
    int          s0;
    int          n;
    logic [7:0]  byt;

    n_tests = 0; n_fail = 0; cyc = 0; mon_en = 1'b0;
    rst_n = 1'b0; io_cs = 1'b0; io_we = 1'b0; io_address = '0; io_wdata = '0;
    repeat (3) @(negedge clk);
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_irq", {31'd0, irq}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Register readback
    bus_read(12'h008, r); check("ctrl_reset", r, 32'h1);
    bus_read(12'h004, r); check("status_reset", r, 32'h4);
    io_address = 12'h008; io_cs = 1'b0; io_we = 1'b0;
    #1 check("rdata_no_cs", io_rdata, 32'h0);
    io_cs = 1'b1; io_we = 1'b1; io_wdata = 32'h1;
    #1 check("rdata_we", io_rdata, 32'h0);
    io_cs = 1'b0; io_we = 1'b0;
    bus_read(12'h010, r); check("unmapped_read", r, 32'h0);
    @(negedge clk);

    // Reset in the middle of a frame
    bus_write(12'h000, 32'h55);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1 check("async_reset_tx", {31'd0, tx}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    bus_read(12'h004, r); check("status_after_reset", r, 32'h4);
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("no_resume_after_reset", lows, 0);
    mon_en = 1'b1;

    // Single byte and start latency
    exp_q.push_back(8'hA5);
    io_cs = 1'b1; io_we = 1'b1; io_address = 12'h000; io_wdata = 32'hA5;
    @(posedge clk); #1;
    check("tx_high_at_write_edge", {31'd0, tx}, 32'd1);
    io_cs = 1'b0; io_we = 1'b0;
    @(posedge clk); #1;
    check("tx_low_next_edge", {31'd0, tx}, 32'd0);
    wait_drain("single", 200);
    bus_read(12'h004, r); check("busy_clear", r, 32'h4);

    // Back-to-back frames
    s0 = starts.size();
    exp_q.push_back(8'h01); exp_q.push_back(8'h02);
    @(negedge clk);
    bus_write(12'h000, 32'h01);
    bus_write(12'h000, 32'h02);
    wait_drain("b2b", 300);
    if (starts.size() >= s0 + 2) check("b2b_gap", starts[s0+1] - starts[s0], FRAME);
    else check("b2b_frames", starts.size() - s0, 2);

    // Overflow with transmitter disabled
    bus_write(12'h008, 32'h0);
    for (int i = 0; i < 5; i++) begin
      if (i < FIFO_DEPTH) exp_q.push_back(8'hC0 + 8'(i));
      bus_write(12'h000, 32'hC0 + i);
    end
    bus_read(12'h004, r); check("status_overflow", r, 32'h40A);
    bus_write(12'h004, 32'h0);
    bus_read(12'h004, r); check("w1c_zero_keeps", r, 32'h40A);
    bus_write(12'h004, 32'h8);
    bus_read(12'h004, r); check("w1c_clears", r, 32'h402);
    s0 = starts.size();
    bus_write(12'h008, 32'h1);
    wait_drain("ovf", 600);
    check("ovf_frames", starts.size() - s0, 4);

    // CTRL irq_en and interrupt behaviour
    bus_write(12'h008, 32'h3);
    bus_read(12'h008, r);
`ifdef UART_TX_IRQ_EN
    check("ctrl_irq_en_rw", r, 32'h3);
    @(negedge clk); @(negedge clk);
    check("irq_idle_empty", {31'd0, irq}, 32'd1);
    exp_q.push_back(8'h33);
    io_cs = 1'b1; io_we = 1'b1; io_address = 12'h000; io_wdata = 32'h33;
    @(posedge clk); #1;
    check("irq_clear_on_push", {31'd0, irq}, 32'd0);
    io_cs = 1'b0; io_we = 1'b0;
    repeat (FRAME + 1) @(posedge clk);
    #1 check("irq_low_at_stop_end", {31'd0, irq}, 32'd0);
    @(posedge clk);
    #1 check("irq_return", {31'd0, irq}, 32'd1);
    @(negedge clk);
    bus_write(12'h008, 32'h1);
    check("irq_clear_on_disable", {31'd0, irq}, 32'd0);
`else
    check("ctrl_irq_en_ignored", r, 32'h1);
    @(negedge clk); @(negedge clk);
    check("irq_tied_low", {31'd0, irq}, 32'd0);
    bus_write(12'h008, 32'h1);
`endif
    wait_drain("irq", 300);

    // Randomized bursts against the byte-queue model
    for (int round = 0; round < 8; round++) begin
      n = $urandom_range(1, FIFO_DEPTH);
      for (int i = 0; i < n; i++) begin
        byt = 8'($urandom);
        exp_q.push_back(byt);
        bus_write(12'h000, {24'd0, byt});
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_drain("random", 800);
      bus_read(12'h004, r); check("random_status_idle", r, 32'h4);
    end

    repeat (5) @(negedge clk);
    check("exp_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/io_uart_tx_dev.md
Name: io_uart_tx_dev

Overview:
- Memory-mapped UART transmitter device that responds on one io_cs slot of the CPU IO bus (address/cs/we/wdata in, rdata out).
- CPU writes bytes into a small TX FIFO; an 8N1 serializer drains the FIFO onto the tx pin at CLK_DIV clocks per bit.
- Read data is combinational from registers, so the bus read mux sees it in the same cycle.

Parameters:
- CLK_DIV, 434, clocks per serial bit (>=2); 434 gives 115200 baud at 50 MHz.
- FIFO_DEPTH, 8, TX FIFO entries; power of two, 2..64.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- io_address  input  12  bus address; only [7:0] decoded, word offsets.
- io_cs  input  1  chip select for this device (one bit of the bus io_cs).
- io_we  input  1  write enable, qualified by io_cs.
- io_wdata  input  32  write data.
- io_rdata  output  32  read data; combinational.
- tx  output  1  serial line, idle high.
- irq  output  1  interrupt request; active-high, level.

Behaviour:
- Register map (io_address[7:0]); other offsets read 0 and ignore writes:
  - 0x00 TXDATA: write pushes io_wdata[7:0]; read returns 0.
  - 0x04 STATUS (RO, except bit3 is W1C):
    - bit0 busy (state != IDLE)
    - bit1 full
    - bit2 empty
    - bit3 overflow
    - bits[14:8] count (zero-extended)
  - 0x08 CTRL (RW): bit0 tx_en (reset 1); bit1 irq_en (reset 0).
- io_rdata = selected register when io_cs && !io_we; otherwise 32'h0.
- Writes take effect on the rising clk edge where io_cs && io_we.
- FIFO:
  - Read/write pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
  - Push while full is dropped and sets overflow. This holds even if a pop occurs in the same cycle.
  - If an overflow set and a W1C clear happen in the same cycle, set wins.
- Serializer FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on the first edge where tx_en && !empty: pop the head byte into the shift register and drive tx=0 (registered). A write at edge N therefore gives tx low after edge N+1.
  - Each state holds for exactly CLK_DIV clocks using a baud counter that reloads on every state or bit change.
  - DATA: 8 bits, LSB first, bit index 0..7.
  - STOP: tx=1 for CLK_DIV clocks, then:
    - pop the next byte directly into START if tx_en && !empty (back-to-back frames, no idle gap);
    - otherwise go to IDLE.
  - Clearing tx_en never aborts a frame; it only blocks the next pop.
- Reset (async, any time, including mid-frame):
  - tx=1, state=IDLE, FIFO emptied, overflow=0, tx_en=1, irq_en=0.
  - irq=0, io_rdata=0 when not selected.
  - No partial frame resumes after reset.

Optional Feature:
- Macro UART_TX_IRQ_EN.
- Defined: irq = irq_en && empty && !busy, registered (one-cycle lag). It clears when a byte is pushed or irq_en is cleared.
- Undefined: irq tied 0; CTRL bit1 reads 0 and ignores writes.

Decomposition:
- Shared package holds:
  - register offset constants (TXDATA_OFS, STATUS_OFS, CTRL_OFS);
  - STATUS/CTRL bit-position constants;
  - FSM state encoding (2-bit enum).
- One natural sub-module: io_sync_fifo (parameterised width/depth; push/pop/full/empty/count). The top level holds the register decode, FSM, baud counter and shift register.

Test Plan (CLK_DIV=4, FIFO_DEPTH=4):
- Reset mid-frame: write 0x55, assert rst_n=0 during DATA -> tx=1 immediately; STATUS reads 0x4 (empty); no further tx edges.
- Single byte: write 0xA5 to 0x00 -> tx low after the next edge for 4 clks; then bits 1,0,1,0,0,1,0,1 at 4 clks each; stop high 4 clks; busy then clears.
- Back-to-back: write 0x01, 0x02 on consecutive cycles -> the second start bit begins exactly 40 clks after the first; no idle gap.
- Overflow: tx_en=0, write 5 bytes -> STATUS = full|count=4|overflow (0x40A); write 0x8 to 0x04 -> overflow=0; set tx_en=1 -> 4 frames sent.
- Readback: read 0x08 after reset -> 0x1; io_rdata=0 when io_cs=0 or io_we=1; unmapped offset 0x10 reads 0.
- UART_TX_IRQ_EN: set irq_en, FIFO idle -> irq=1; push 0x33 -> irq=0 the next cycle; irq returns to 1 one cycle after STOP ends.
